condicionador_jogada: RTL and testbench

CONDICIONADOR_JOGADA -- requirements
Module: condicionador_jogada

---
 rtl/condicionador_jogada_pkg.sv | 21 ++
 rtl/condicionador_jogada_sincronizador.sv | 28 ++
 rtl/condicionador_jogada.sv | 136 +++++++++++++
 tb/tb_condicionador_jogada.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/condicionador_jogada_pkg.sv
// Shared game package: FSM state codes, debounce default and a one-hot helper
// used by the play conditioner and its testbench.
package condicionador_jogada_pkg;

  // Default number of consecutive equal synchronized samples to accept a level.
  localparam int N_DEBOUNCE_PADRAO = 2;

  // Codes are visible on db_estado, so they are fixed explicitly.
  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    FILTRANDO      = 3'd1,
    CAPTURADO      = 3'd2,
    INVALIDO       = 3'd3,
    AGUARDA_SOLTAR = 3'd4
  } estado_t;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/condicionador_jogada_sincronizador.sv
// Two-flop synchronizer for the raw push-buttons.
// Ports:
//   clock - system clock (rising edge)
//   reset - synchronous, active-high; clears both flop stages
//   d     - asynchronous input bus
//   q     - synchronized output bus (two cycles of latency)
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condicionador_jogada.sv
// Play conditioner: synchronizes and debounces four push-buttons, emits a
// one-cycle pulse for an accepted one-hot press (or for a rejected multi-button
// press), then waits for a debounced release before arming again.
// Ports:
//   clock           - system clock (rising edge)
//   reset           - synchronous, active-high
//   habilita        - presses are accepted only while high (sampled in OCIOSO)
//   botoes[3:0]     - raw asynchronous buttons, active-high
//   jogada_feita    - one-cycle pulse, valid one-hot press accepted
//   jogada[3:0]     - registered one-hot code of the last accepted press
//   jogada_invalida - one-cycle pulse, stable multi-button press rejected
//   ocupado         - high whenever the FSM is not in OCIOSO
//   db_estado[2:0]  - current FSM state code
module condicionador_jogada
  import condicionador_jogada_pkg::*;
#(
  parameter int N_DEBOUNCE = N_DEBOUNCE_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  localparam int CW = (N_DEBOUNCE < 2) ? 1 : $clog2(N_DEBOUNCE + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N_DEBOUNCE);
  // With a single required sample the entry sample already settles the press.
  localparam logic DECIDE_NA_ENTRADA = (N_DEBOUNCE <= 1);

  logic [3:0]    s;
  estado_t       estado, estado_n;
  logic [3:0]    cand, cand_n, jog, jog_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          decidir;
  logic [3:0]    alvo;

  sincronizador_2ff #(.W(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      cand   <= '0;
      jog    <= '0;
      cnt    <= '0;
    end else begin
      estado <= estado_n;
      cand   <= cand_n;
      jog    <= jog_n;
      cnt    <= cnt_n;
    end
  end

  // Saturating increment; the counter is shared by the press filter and the
  // release filter since the two never run at the same time.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_comb begin
    estado_n = estado;
    cand_n   = cand;
    jog_n    = jog;
    cnt_n    = cnt;
    decidir  = 1'b0;
    alvo     = cand;
    case (estado)
      OCIOSO: begin
        if (s != 4'd0) begin
          if (habilita) begin
            cand_n   = s;
            cnt_n    = CW'(1);
            estado_n = FILTRANDO;
            decidir  = DECIDE_NA_ENTRADA;
            alvo     = s;
          end else begin
            // Button already down while disabled: must be released first.
            estado_n = AGUARDA_SOLTAR;
            cnt_n    = '0;
          end
        end
      end
      FILTRANDO: begin
        if (s == 4'd0) begin
          estado_n = OCIOSO;
        end else if (s != cand) begin
          cand_n  = s;
          cnt_n   = CW'(1);
          decidir = DECIDE_NA_ENTRADA;
          alvo    = s;
        end else begin
          cnt_n   = cnt_inc;
          decidir = (cnt_inc >= N_CNT);
        end
      end
      CAPTURADO, INVALIDO: begin
        estado_n = AGUARDA_SOLTAR;
        cnt_n    = '0;
      end
      AGUARDA_SOLTAR: begin
        if (s != 4'd0) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= N_CNT) estado_n = OCIOSO;
        end
      end
      default: estado_n = OCIOSO;
    endcase

    // jogada is loaded on the same edge that enters CAPTURADO so the code is
    // valid together with the pulse.
    if (decidir) begin
      if (eh_one_hot(alvo)) begin
        estado_n = CAPTURADO;
        jog_n    = alvo;
      end else begin
        estado_n = INVALIDO;
      end
    end
  end

  assign jogada_feita    = (estado == CAPTURADO);
  assign jogada_invalida = (estado == INVALIDO);
  assign ocupado         = (estado != OCIOSO);
  assign db_estado       = estado;
  assign jogada          = jog;

endmodule

// File: tb/tb_condicionador_jogada.sv
// Self-checking bench for condicionador_jogada: directed scenarios with literal
// expectations plus randomized button traffic compared every cycle against a
// behavioural model of the synchronize / debounce / release rules.
module tb_condicionador_jogada;

  localparam int N = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       ocupado;
  logic [2:0] db_estado;

  int vectors = 0;
  int miscompares = 0;
  int n_feita = 0;
  int n_inval = 0;

  condicionador_jogada #(.N_DEBOUNCE(N)) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .botoes          (botoes),
    .jogada_feita    (jogada_feita),
    .jogada          (jogada),
    .jogada_invalida (jogada_invalida),
    .ocupado         (ocupado),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // mode uses the externally visible state codes: 0 idle, 1 filtering,
  // 2 captured, 3 invalid, 4 waiting for release.
  logic [3:0] m_ff1 = '0, m_s = '0, m_cand = '0, m_jog = '0;
  int         m_mode = 0, m_cnt = 0;

  always @(posedge clock) begin
    automatic int         mode = m_mode;
    automatic int         cnt  = m_cnt;
    automatic logic [3:0] cand = m_cand;
    automatic logic [3:0] jog  = m_jog;
    automatic logic       settle = 1'b0;
    if (reset) begin
      m_ff1 <= '0; m_s <= '0; m_cand <= '0; m_jog <= '0;
      m_mode <= 0; m_cnt <= 0;
    end else begin
      if (m_mode == 0) begin
        if (m_s != 0 && habilita) begin
          cand = m_s; cnt = 1; mode = 1; settle = (cnt >= N);
        end else if (m_s != 0) begin
          mode = 4; cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (m_s == 0) mode = 0;
        else begin
          if (m_s != cand) begin cand = m_s; cnt = 1; end
          else cnt = cnt + 1;
          settle = (cnt >= N);
        end
      end else if (m_mode == 2 || m_mode == 3) begin
        mode = 4; cnt = 0;
      end else begin
        if (m_s != 0) cnt = 0;
        else begin
          cnt = cnt + 1;
          if (cnt >= N) mode = 0;
        end
      end
      if (settle) begin
        if ($countones(cand) == 1) begin mode = 2; jog = cand; end
        else mode = 3;
      end
      m_s <= m_ff1; m_ff1 <= botoes;
      m_mode <= mode; m_cnt <= cnt; m_cand <= cand; m_jog <= jog;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("db_estado", {29'd0, db_estado}, 32'(m_mode));
    chk("jogada_feita", {31'd0, jogada_feita}, {31'd0, m_mode == 2});
    chk("jogada_invalida", {31'd0, jogada_invalida}, {31'd0, m_mode == 3});
    chk("ocupado", {31'd0, ocupado}, {31'd0, m_mode != 0});
    chk("jogada", {28'd0, jogada}, {28'd0, m_jog});
    chk("pulses_exclusive", {31'd0, jogada_feita & jogada_invalida}, 32'd0);
    if (jogada_feita) n_feita++;
    if (jogada_invalida) n_inval++;
  endtask

  // Advance n cycles; each step ends at a falling edge and checks the model.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      chk_model();
    end
  endtask

  task automatic clr();
    n_feita = 0;
    n_inval = 0;
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; botoes = 4'd0;
    step(2);
    chk("reset_estado", {29'd0, db_estado}, 32'd0);
    chk("reset_jogada", {28'd0, jogada}, 32'd0);
    chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
    reset = 1'b0;

    // single short press 0010
    clr(); habilita = 1'b1; botoes = 4'b0010;
    step(2); botoes = 4'd0;
    step(1); chk("t1_no_pulse_edge3", {31'd0, jogada_feita}, 32'd0);
    step(1); chk("t1_pulse_edge4", {31'd0, jogada_feita}, 32'd1);
    chk("t1_jogada", {28'd0, jogada}, 32'h2);
    step(6); chk("t1_idle", {29'd0, db_estado}, 32'd0);
    chk("t1_one_pulse", 32'(n_feita), 32'd1);

    // multi-button press rejected
    clr(); botoes = 4'b0011;
    step(5); botoes = 4'd0; step(10);
    chk("t2_inval", 32'(n_inval), 32'd1);
    chk("t2_feita", 32'(n_feita), 32'd0);
    chk("t2_jogada_kept", {28'd0, jogada}, 32'h2);
    chk("t2_idle", {29'd0, db_estado}, 32'd0);

    // press while disabled, enable while held
    clr(); habilita = 1'b0; botoes = 4'b0100;
    step(6); chk("t3_busy", {31'd0, ocupado}, 32'd1);
    habilita = 1'b1; step(6);
    chk("t3_no_pulse_held", 32'(n_feita + n_inval), 32'd0);
    botoes = 4'd0; step(6);
    chk("t3_no_pulse_release", 32'(n_feita), 32'd0);
    botoes = 4'b0100; step(6);
    chk("t3_repress", 32'(n_feita), 32'd1);
    chk("t3_jogada", {28'd0, jogada}, 32'h4);
    botoes = 4'd0; step(6);

    // long hold
    clr(); botoes = 4'b0001; step(20); botoes = 4'd0; step(6);
    chk("t4_one_pulse", 32'(n_feita), 32'd1);
    chk("t4_jogada", {28'd0, jogada}, 32'h1);

    // habilita drops mid-filter
    clr(); botoes = 4'b0010; step(3);
    chk("t5_filtering", {29'd0, db_estado}, 32'd1);
    habilita = 1'b0; step(1);
    chk("t5_pulse", {31'd0, jogada_feita}, 32'd1);
    botoes = 4'd0; step(6); habilita = 1'b1;

    // glitch rejected, then real press
    clr(); botoes = 4'b0001; step(1); botoes = 4'd0; step(6);
    chk("t6_glitch", 32'(n_feita + n_inval), 32'd0);
    botoes = 4'b1000; step(3); botoes = 4'd0; step(6);
    chk("t6_pulse", 32'(n_feita), 32'd1);
    chk("t6_jogada", {28'd0, jogada}, 32'h8);

    // reset during filtering, button held through release
    clr(); botoes = 4'b0001; step(3);
    chk("t7_filtering", {29'd0, db_estado}, 32'd1);
    reset = 1'b1; step(1);
    chk("t7_rst_estado", {29'd0, db_estado}, 32'd0);
    chk("t7_rst_jogada", {28'd0, jogada}, 32'd0);
    chk("t7_rst_busy", {31'd0, ocupado}, 32'd0);
    reset = 1'b0; step(3);
    chk("t7_no_pulse_yet", {31'd0, jogada_feita}, 32'd0);
    step(1);
    chk("t7_pulse", {31'd0, jogada_feita}, 32'd1);
    chk("t7_jogada", {28'd0, jogada}, 32'h1);
    botoes = 4'd0; step(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 40) botoes = 4'd0;
      else if (r < 80) botoes = 4'b0001 << $urandom_range(0, 3);
      else botoes = 4'($urandom_range(1, 15));
      habilita = ($urandom_range(0, 99) < 80);
      reset = ($urandom_range(0, 99) < 2);
      step(1);
      reset = 1'b0;
      step($urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
